// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer sequencer: FSM state encoding,
// byte width and the round-robin pointer advance.
package spi_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_START,
      ST_WAIT_BUSY,
      ST_WAIT_DONE,
      ST_HOLD
   } state_e;

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nreq);
      return (idx + 1 >= nreq) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr_i,
// wrapping, returned as a one-hot grant plus its index.
module spi_rr_arbiter
   import spi_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int IDX_W = (NREQ > 2) ? 2 : 1
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] rr_ptr_i,
   output logic             any_o,
   output logic [NREQ-1:0]  grant_o,
   output logic [IDX_W-1:0] idx_o
);

   int pos;

   always_comb begin
      any_o   = 1'b0;
      grant_o = '0;
      idx_o   = '0;
      pos     = 0;
      for (int i = 0; i < NREQ; i++) begin
         pos = int'(rr_ptr_i) + i;
         if (pos >= NREQ) pos = pos - NREQ;
         if (!any_o && req_i[pos]) begin
            any_o        = 1'b1;
            grant_o[pos] = 1'b1;
            idx_o        = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Shares one 8-bit SPI master driver between NREQ requesters: round-robin grant,
// one chip-select window per burst of len+1 bytes, TX/RX byte hand-off per byte.
module spi_xfer_sequencer
   import spi_pkg::*;
#(
   parameter int NREQ     = 2,
   parameter int LEN_W    = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int START_TO = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic [NREQ-1:0]         req_i,
   input  logic [NREQ*LEN_W-1:0]   len_bi,
   input  logic [NREQ*BYTE_W-1:0]  tx_data_bi,
   output logic [NREQ-1:0]         tx_ack_o,
   output logic [BYTE_W-1:0]       rx_data_bo,
   output logic [NREQ-1:0]         rx_valid_o,
   output logic [NREQ-1:0]         done_o,
   output logic [NREQ-1:0]         err_o,
   output logic [NREQ-1:0]         grant_bo,
   output logic                    drv_start_o,
   output logic [BYTE_W-1:0]       drv_data_bo,
   input  logic                    drv_busy_i,
   input  logic [BYTE_W-1:0]       drv_data_bi,
   output logic                    drv_cs_o,
   output logic [NREQ-1:0]         spi_cs_n_bo
);

   localparam int IDX_W = (NREQ > 2) ? 2 : 1;
   localparam int TMR_W = 8;

   state_e              state_q;
   logic [IDX_W-1:0]    rr_ptr_q;
   logic [IDX_W-1:0]    idx_q;
   logic [LEN_W-1:0]    cnt_q;
   logic [TMR_W-1:0]    tmr_q;
   logic                err_seen_q;
   logic [NREQ-1:0]     tx_ack_q;
   logic [BYTE_W-1:0]   rx_data_q;
   logic [NREQ-1:0]     rx_valid_q;
   logic [NREQ-1:0]     done_q;
   logic [NREQ-1:0]     err_q;
   logic [NREQ-1:0]     grant_q;
   logic                drv_start_q;
   logic [BYTE_W-1:0]   drv_data_q;
   logic                drv_cs_q;
   logic [NREQ-1:0]     cs_n_q;

   logic                arb_any;
   logic [NREQ-1:0]     arb_grant;
   logic [IDX_W-1:0]    arb_idx;
   logic [BYTE_W-1:0]   tx_sel;

   spi_rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req_i    (req_i),
      .rr_ptr_i (rr_ptr_q),
      .any_o    (arb_any),
      .grant_o  (arb_grant),
      .idx_o    (arb_idx)
   );

   assign tx_sel = tx_data_bi[idx_q*BYTE_W +: BYTE_W];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         tmr_q       <= '0;
         err_seen_q  <= 1'b0;
         tx_ack_q    <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= '0;
         done_q      <= '0;
         err_q       <= '0;
         grant_q     <= '0;
         drv_start_q <= 1'b0;
         drv_data_q  <= '0;
         drv_cs_q    <= 1'b1;
         cs_n_q      <= '1;
      end else begin
         tx_ack_q    <= '0;
         rx_valid_q  <= '0;
         done_q      <= '0;
         err_q       <= '0;
         drv_start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (arb_any) begin
                  idx_q      <= arb_idx;
                  cnt_q      <= len_bi[arb_idx*LEN_W +: LEN_W];
                  grant_q    <= arb_grant;
                  cs_n_q     <= ~arb_grant;
                  drv_cs_q   <= 1'b0;
                  tmr_q      <= '0;
                  err_seen_q <= 1'b0;
                  state_q    <= ST_SETUP;
               end
            end
            // Start is issued on the edge leaving SETUP so CS_n leads it by exactly CS_SETUP.
            ST_SETUP: begin
               if (tmr_q == TMR_W'(CS_SETUP - 1)) begin
                  drv_data_q      <= tx_sel;
                  drv_start_q     <= 1'b1;
                  tx_ack_q[idx_q] <= 1'b1;
                  state_q         <= ST_START;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            ST_START: begin
               tmr_q   <= '0;
               state_q <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (drv_busy_i) begin
                  state_q <= ST_WAIT_DONE;
               end else if (tmr_q == TMR_W'(START_TO - 1)) begin
                  err_q[idx_q] <= 1'b1;
                  err_seen_q   <= 1'b1;
                  tmr_q        <= '0;
                  state_q      <= ST_HOLD;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               if (!drv_busy_i) begin
                  rx_data_q         <= drv_data_bi;
                  rx_valid_q[idx_q] <= 1'b1;
                  if (cnt_q == '0) begin
                     tmr_q   <= '0;
                     state_q <= ST_HOLD;
                  end else begin
                     cnt_q           <= cnt_q - 1'b1;
                     drv_data_q      <= tx_sel;
                     drv_start_q     <= 1'b1;
                     tx_ack_q[idx_q] <= 1'b1;
                     state_q         <= ST_START;
                  end
               end
            end
            ST_HOLD: begin
               if (tmr_q == TMR_W'(CS_HOLD - 1)) begin
                  cs_n_q   <= '1;
                  drv_cs_q <= 1'b1;
                  grant_q  <= '0;
                  if (!err_seen_q) done_q[idx_q] <= 1'b1;
                  rr_ptr_q <= IDX_W'(rr_next(32'(idx_q), NREQ));
                  state_q  <= ST_IDLE;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign tx_ack_o    = tx_ack_q;
   assign rx_data_bo  = rx_data_q;
   assign rx_valid_o  = rx_valid_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign grant_bo    = grant_q;
   assign drv_start_o = drv_start_q;
   assign drv_data_bo = drv_data_q;
   assign drv_cs_o    = drv_cs_q;
   assign spi_cs_n_bo = cs_n_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a loopback driver model
// (each byte sent comes back as the received byte).
module tb_spi_xfer_sequencer;

   localparam int NREQ     = 2;
   localparam int LEN_W    = 4;
   localparam int CS_SETUP = 2;
   localparam int CS_HOLD  = 2;
   localparam int START_TO = 4;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NREQ-1:0]       req;
   logic [NREQ*LEN_W-1:0] len_b;
   logic [NREQ*8-1:0]     tx_b;
   logic [NREQ-1:0]       tx_ack, rx_valid, done, err, grant, cs_n;
   logic [7:0]            rx_data, drv_data_o, drv_data_i;
   logic                  drv_start, drv_busy, drv_cs;

   spi_xfer_sequencer #(
      .NREQ(NREQ), .LEN_W(LEN_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .START_TO(START_TO)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .len_bi(len_b), .tx_data_bi(tx_b),
      .tx_ack_o(tx_ack), .rx_data_bo(rx_data), .rx_valid_o(rx_valid), .done_o(done),
      .err_o(err), .grant_bo(grant), .drv_start_o(drv_start), .drv_data_bo(drv_data_o),
      .drv_busy_i(drv_busy), .drv_data_bi(drv_data_i), .drv_cs_o(drv_cs), .spi_cs_n_bo(cs_n)
   );

   // loopback driver model: busy for 6 cycles after start, then returns the sent byte
   logic       force_idle;
   logic [7:0] sh;
   logic [3:0] bcnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drv_busy <= 1'b0; drv_data_i <= 8'h00; sh <= 8'h00; bcnt <= 4'd0;
      end else if (drv_start && !force_idle) begin
         sh <= drv_data_o; bcnt <= 4'd6; drv_busy <= 1'b1;
      end else if (bcnt != 4'd0) begin
         bcnt <= bcnt - 4'd1;
         if (bcnt == 4'd1) begin
            drv_busy <= 1'b0; drv_data_i <= sh;
         end
      end
   end

   // scoreboard and monitor state
   int n_checks = 0, n_fail = 0, cyc = 0;
   int n_start = 0, n_ack = 0, n_rx = 0, n_done = 0, n_err = 0, n_cs_fall = 0;
   int first_start_cyc = -1, start_cyc = 0, cs_fall_cyc = 0, err_cyc = 0;
   int last_rx_cyc = 0, last_done_cyc = 0;
   logic [1:0] done_last = '0, err_last = '0, cs_at_done = '0, cs_prev = '1, grant_prev = '0;
   logic [7:0] exp_q[$];
   logic [1:0] exp_own_q[$];
   logic [7:0] src0_q[$], src1_q[$];
   logic [1:0] gval_q[$];
   int         ggap_q[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic present();
      tx_b[7:0]  = (src0_q.size() > 0) ? src0_q[0] : 8'h00;
      tx_b[15:8] = (src1_q.size() > 0) ? src1_q[0] : 8'h00;
   endtask

   // one cycle: sample DUT on the falling edge, respond to tx_ack, score rx bytes
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (drv_start) begin
         n_start++;
         if (first_start_cyc < 0) first_start_cyc = cyc;
         start_cyc = cyc;
      end
      if (tx_ack != '0) n_ack++;
      if (tx_ack[0] && src0_q.size() > 0) void'(src0_q.pop_front());
      if (tx_ack[1] && src1_q.size() > 0) void'(src1_q.pop_front());
      present();
      if (rx_valid != '0) begin
         n_rx++;
         last_rx_cyc = cyc;
         check_eq("rx_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            check_eq("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            check_eq("rx_owner", 32'(rx_valid), 32'(exp_own_q.pop_front()));
         end
      end
      if (done != '0) begin
         n_done++; done_last = done; last_done_cyc = cyc; cs_at_done = cs_n;
      end
      if (err != '0) begin
         n_err++; err_last = err; err_cyc = cyc;
      end
      if (cs_prev == 2'b11 && cs_n != 2'b11) begin
         n_cs_fall++; cs_fall_cyc = cyc;
      end
      if (grant_prev == 2'b00 && grant != 2'b00) begin
         gval_q.push_back(grant);
         ggap_q.push_back(cyc - last_done_cyc);
      end
      cs_prev = cs_n;
      grant_prev = grant;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_end(input int max_cyc);
      int base;
      bit ok;
      base = n_done + n_err;
      ok = 1'b0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         tick();
         if (n_done + n_err > base) ok = 1'b1;
      end
      check_eq("end_in_time", 32'(ok), 32'd1);
   endtask

   int b_start, b_ack, b_rx, b_done, b_err, b_cs;

   task automatic snap();
      b_start = n_start; b_ack = n_ack; b_rx = n_rx;
      b_done = n_done; b_err = n_err; b_cs = n_cs_fall;
   endtask

   initial begin
      rst_n = 1'b0; req = '0; len_b = '0; tx_b = '0; force_idle = 1'b0;
      ticks(3);
      rst_n = 1'b1;
      tick();
      check_eq("rst_grant", 32'(grant), 32'h0);
      check_eq("rst_cs_n", 32'(cs_n), 32'h3);
      check_eq("rst_drv_cs", 32'(drv_cs), 32'h1);
      check_eq("rst_pulses", 32'({tx_ack, rx_valid, done, err, drv_start}), 32'h0);
      check_eq("rst_data", 32'({rx_data, drv_data_o}), 32'h0);
      ticks(3);
      check_eq("idle_no_req", 32'({grant, drv_start}), 32'h0);

      // T1: single byte A5 for requester 0
      snap(); first_start_cyc = -1;
      src0_q = '{8'hA5}; present(); exp_q.push_back(8'hA5); exp_own_q.push_back(2'b01);
      len_b[3:0] = 4'h0; req = 2'b01;
      wait_end(200); req = '0;
      check_eq("t1_setup", 32'(first_start_cyc - cs_fall_cyc), 32'(CS_SETUP));
      check_eq("t1_starts", 32'(n_start - b_start), 32'd1);
      check_eq("t1_acks", 32'(n_ack - b_ack), 32'd1);
      check_eq("t1_rx", 32'(n_rx - b_rx), 32'd1);
      check_eq("t1_done", 32'(done_last), 32'h1);
      check_eq("t1_hold", 32'(last_done_cyc - last_rx_cyc), 32'(CS_HOLD));
      check_eq("t1_cs_at_done", 32'(cs_at_done), 32'h3);
      tick();
      check_eq("t1_grant_idle", 32'({grant, drv_cs}), 32'h1);

      // T2: four bytes under one CS window
      snap();
      src0_q = '{8'h11, 8'h22, 8'h33, 8'h44}; present();
      foreach (src0_q[i]) begin exp_q.push_back(src0_q[i]); exp_own_q.push_back(2'b01); end
      len_b[3:0] = 4'h3; req = 2'b01;
      wait_end(300); req = '0;
      check_eq("t2_acks", 32'(n_ack - b_ack), 32'd4);
      check_eq("t2_rx", 32'(n_rx - b_rx), 32'd4);
      check_eq("t2_cs_windows", 32'(n_cs_fall - b_cs), 32'd1);
      check_eq("t2_left", 32'(exp_q.size()), 32'd0);
      ticks(2);

      // T3: both requesting; rr_ptr is 1 after T2, so order is 10,01,10,01
      snap(); gval_q.delete(); ggap_q.delete();
      src0_q = '{8'hA1, 8'hA2}; src1_q = '{8'hB1, 8'hB2}; present();
      exp_q = '{8'hB1, 8'hA1, 8'hB2, 8'hA2};
      exp_own_q = '{2'b10, 2'b01, 2'b10, 2'b01};
      len_b = '0; req = 2'b11;
      for (int k = 0; k < 4; k++) wait_end(200);
      req = '0;
      ticks(3);
      check_eq("t3_bursts", 32'(n_done - b_done), 32'd4);
      check_eq("t3_grants", 32'(gval_q.size()), 32'd4);
      if (gval_q.size() == 4) begin
         check_eq("t3_g0", 32'(gval_q[0]), 32'h2);
         check_eq("t3_g1", 32'(gval_q[1]), 32'h1);
         check_eq("t3_g2", 32'(gval_q[2]), 32'h2);
         check_eq("t3_g3", 32'(gval_q[3]), 32'h1);
         for (int k = 1; k < 4; k++) check_eq("t3_gap", 32'(ggap_q[k]), 32'd1);
      end

      // T4: driver never goes busy
      snap(); force_idle = 1'b1;
      src0_q = '{8'h5A, 8'h6B}; present();
      len_b[3:0] = 4'h1; req = 2'b01;
      wait_end(200); req = '0;
      check_eq("t4_err", 32'(err_last), 32'h1);
      check_eq("t4_err_delay", 32'(err_cyc - start_cyc), 32'(START_TO + 1));
      check_eq("t4_starts", 32'(n_start - b_start), 32'd1);
      ticks(CS_HOLD + 2);
      check_eq("t4_no_done", 32'(n_done - b_done), 32'd0);
      check_eq("t4_no_rx", 32'(n_rx - b_rx), 32'd0);
      check_eq("t4_cs_n", 32'({cs_n, grant}), 32'hC);
      force_idle = 1'b0; src0_q.delete(); present();

      // T5: reset in the middle of byte 2 of 4
      snap();
      src0_q = '{8'h31, 8'h32, 8'h33, 8'h34}; present();
      foreach (src0_q[i]) begin exp_q.push_back(src0_q[i]); exp_own_q.push_back(2'b01); end
      len_b[3:0] = 4'h3; req = 2'b01;
      for (int i = 0; i < 100 && n_rx == b_rx; i++) tick();
      check_eq("t5_first_rx", 32'(n_rx - b_rx), 32'd1);
      ticks(4);
      check_eq("t5_cs_low", 32'(cs_n), 32'h2);
      #2 rst_n = 1'b0;
      #1 check_eq("t5_cs_async", 32'({cs_n, drv_cs}), 32'h7);
      req = '0; exp_q.delete(); exp_own_q.delete(); src0_q.delete(); present();
      ticks(2);
      rst_n = 1'b1;
      ticks(3);
      check_eq("t5_grant", 32'(grant), 32'h0);
      check_eq("t5_no_end", 32'((n_done - b_done) + (n_err - b_err)), 32'd0);

      // T6: maximum burst of 16 bytes
      snap();
      for (int i = 0; i < 16; i++) begin
         src0_q.push_back(8'(i * 17 + 3));
         exp_q.push_back(8'(i * 17 + 3));
         exp_own_q.push_back(2'b01);
      end
      present();
      len_b[3:0] = 4'hF; req = 2'b01;
      wait_end(600); req = '0;
      check_eq("t6_rx", 32'(n_rx - b_rx), 32'd16);
      check_eq("t6_acks", 32'(n_ack - b_ack), 32'd16);
      check_eq("t6_done", 32'(done_last), 32'h1);
      check_eq("t6_left", 32'(exp_q.size()), 32'd0);
      ticks(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
